seg_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for the 8-digit common-anode 7-segment display.

---
 rtl/seg_pkg.sv | 41 ++++
 rtl/seg7_hex_dec.sv | 15 +
 rtl/seg_scan_ctrl.sv | 112 +++++++++++
 tb/tb_seg_scan_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants, types and the hex-to-segment table
// for the 7-segment scan controller.
package seg_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int IDX_W      = 3;

  localparam logic [NUM_DIGITS-1:0] AN_OFF  = 8'hFF;
  localparam logic [6:0]            SEG_OFF = 7'h7F;

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] data;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   en;
  } shadow_t;

  // Active-low {g,f,e,d,c,b,a} glyph for one hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_hex_dec.sv
// Nibble to active-low 7-segment decoder.
// Purely combinational.
module seg7_hex_dec
  import seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  // Table lookup for the current digit's nibble.
  always_comb begin
    seg_o = hex7(nib_i);
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 8-digit scan controller with blanking dead-time
// and frame-boundary double-buffered display update.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 1000,
  parameter int CNT_W     = 17
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] disp_data,
  input  logic [NUM_DIGITS-1:0]   disp_dp,
  input  logic [NUM_DIGITS-1:0]   disp_en,
  input  logic                    upd_req,
  output logic                    upd_ack,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp_n
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_V = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  shadow_t               sh_q, sh_d;
  logic                  ack_q, ack_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;

  logic                  slot_end;
  logic                  frame_end;
  logic [3:0]            nib;
  logic [6:0]            seg_hex;

  // Prescaler and digit index stepping.
  always_comb begin
    slot_end  = (cnt_q == CNT_MAX);
    frame_end = slot_end && (idx_q == IDX_MAX);
    cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
    idx_d     = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end
  end

  // Shadow reload and ack only at the frame boundary.
  always_comb begin
    sh_d  = sh_q;
    ack_d = 1'b0;
    if (frame_end && upd_req) begin
      sh_d.data = disp_data;
      sh_d.dp   = disp_dp;
      sh_d.en   = disp_en;
      ack_d     = 1'b1;
    end
  end

  // The glyph comes from next-state shadow so that
  // fresh data lines up with digit 0 of the new frame.
  always_comb begin
    nib = sh_d.data[{idx_d, 2'b00} +: 4];
  end

  seg7_hex_dec u_dec (
    .nib_i (nib),
    .seg_o (seg_hex)
  );

  // Pin values from next-state so they match cnt/idx.
  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if ((cnt_d >= BLANK_V) && sh_d.en[idx_d]) begin
      an_d        = AN_OFF;
      an_d[idx_d] = 1'b0;
      seg_d       = seg_hex;
      dp_d        = ~sh_d.dp[idx_d];
    end
  end

  // State and output registers; reset blanks the pins at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
      sh_q  <= '0;
      ack_q <= 1'b0;
      an_q  <= AN_OFF;
      seg_q <= SEG_OFF;
      dp_q  <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      sh_q  <= sh_d;
      ack_q <= ack_d;
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign upd_ack = ack_q;
  assign an      = an_q;
  assign seg     = seg_q;
  assign dp_n    = dp_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with SCAN_DIV=8, BLANK_CYC=2.
// Cycle-indexed reference tracks slot, digit, shadow and ack.
module tb_seg_scan_ctrl;

  localparam logic [6:0] HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] disp_data;
  logic [7:0]  disp_dp;
  logic [7:0]  disp_en;
  logic        upd_req;
  logic        upd_ack;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp_n;

  int          checks = 0;
  int          errors = 0;
  int          k = 0;
  logic [31:0] m_data;
  logic [7:0]  m_dp;
  logic [7:0]  m_en;
  logic        exp_ack;
  int          a1;
  int          a2;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .SCAN_DIV  (8),
    .BLANK_CYC (2),
    .CNT_W     (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .disp_data (disp_data),
    .disp_dp   (disp_dp),
    .disp_en   (disp_en),
    .upd_req   (upd_req),
    .upd_ack   (upd_ack),
    .an        (an),
    .seg       (seg),
    .dp_n      (dp_n)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h k=%0d", tag, got, exp, k);
    end
  endtask

  task automatic chk_cycle();
    int c;
    int i;
    logic [7:0] ea;
    logic [6:0] es;
    logic       ed;
    c  = k % 8;
    i  = (k / 8) % 8;
    ea = 8'hFF;
    es = 7'h7F;
    ed = 1'b1;
    if (c >= 2 && m_en[i]) begin
      ea[i] = 1'b0;
      es    = HEX[m_data[4*i +: 4]];
      ed    = ~m_dp[i];
    end
    chk("an", an, ea);
    chk("seg", seg, es);
    chk("dp_n", dp_n, ed);
    chk("ack", upd_ack, exp_ack);
    chk("onehot", ($countones(~an) <= 1), 1);
  endtask

  task automatic cyc();
    logic pend;
    pend = (k % 64 == 63) && upd_req;
    @(negedge clk);
    k++;
    exp_ack = pend;
    if (pend) begin
      m_data = disp_data;
      m_dp   = disp_dp;
      m_en   = disp_en;
    end
    chk_cycle();
  endtask

  task automatic run_to(input int kk);
    while (k < kk) cyc();
  endtask

  initial begin
    rst_n     = 1'b0;
    disp_data = '0;
    disp_dp   = '0;
    disp_en   = '0;
    upd_req   = 1'b0;
    m_data    = '0;
    m_dp      = '0;
    m_en      = '0;
    exp_ack   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst an", an, 8'hFF);
    chk("rst seg", seg, 7'h7F);
    chk("rst dp", dp_n, 1'b1);
    chk("rst ack", upd_ack, 1'b0);

    // 1: load 76543210 at the first boundary
    disp_data = 32'h7654_3210;
    disp_en   = 8'hFF;
    rst_n     = 1'b1;
    k         = 0;
    chk_cycle();
    run_to(63);
    upd_req = 1'b1;
    cyc();
    upd_req = 1'b0;
    chk("t1 ack", upd_ack, 1'b1);
    run_to(65);
    chk("t1 blank", an, 8'hFF);
    cyc();
    chk("t1 d0 seg", seg, 7'h40);
    chk("t1 d0 an", an, 8'hFE);
    run_to(122);
    chk("t1 d7 seg", seg, 7'h78);
    chk("t1 d7 an", an, 8'h7F);
    run_to(127);

    // 3: alternate digits dark, dp only on disabled digit 0
    disp_en = 8'b1010_1010;
    disp_dp = 8'h01;
    upd_req = 1'b1;
    cyc();
    upd_req = 1'b0;
    run_to(132);
    chk("t3 d0 dark", an, 8'hFF);
    chk("t3 d0 dp", dp_n, 1'b1);
    run_to(139);
    chk("t3 d1 on", an, 8'hFD);
    chk("t3 d1 dp", dp_n, 1'b1);
    run_to(200);

    // 4: mid-frame request waits for the boundary
    disp_data = 32'hFFFF_FFFF;
    disp_en   = 8'hFF;
    disp_dp   = 8'h00;
    upd_req   = 1'b1;
    run_to(255);
    chk("t4 old seg", seg, 7'h78);
    chk("t4 no ack", upd_ack, 1'b0);
    cyc();
    upd_req = 1'b0;
    chk("t4 ack", upd_ack, 1'b1);
    cyc();
    chk("t4 ack pulse", upd_ack, 1'b0);
    run_to(258);
    chk("t4 F seg", seg, 7'h0E);
    run_to(300);

    // 5: request held across two boundaries
    a1 = -1;
    a2 = -1;
    upd_req = 1'b1;
    while (k < 390) begin
      cyc();
      if (upd_ack === 1'b1) begin
        if (a1 < 0) a1 = k;
        else if (a2 < 0) a2 = k;
      end
    end
    upd_req = 1'b0;
    chk("t5 ack1", a1, 320);
    chk("t5 gap", a2 - a1, 64);

    // 6: reset during SHOW of digit 5
    run_to(428);
    chk("t6 pre an", an, 8'hDF);
    rst_n = 1'b0;
    #1;
    chk("t6 an", an, 8'hFF);
    chk("t6 seg", seg, 7'h7F);
    chk("t6 dp", dp_n, 1'b1);
    chk("t6 ack", upd_ack, 1'b0);
    @(negedge clk);
    rst_n   = 1'b1;
    k       = 0;
    m_data  = '0;
    m_dp    = '0;
    m_en    = '0;
    exp_ack = 1'b0;
    chk_cycle();
    run_to(20);
    chk("t6 cleared", an, 8'hFF);
    disp_data = 32'h0;
    disp_en   = 8'h01;
    run_to(63);
    upd_req = 1'b1;
    cyc();
    upd_req = 1'b0;
    run_to(66);
    chk("t6 d0 seg", seg, 7'h40);
    chk("t6 d0 an", an, 8'hFE);
    run_to(74);
    chk("t6 d1 dark", an, 8'hFF);
    run_to(128);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
